// File: rtl/collision_query_arbiter_pkg.sv
// Shared defaults, widths and helpers for the collision query arbiter.
package collision_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int MAP_W_DEF   = 500;
  localparam int MAP_H_DEF   = 500;

  localparam int COORD_W = 9;
  localparam int ADDR_W  = 18;
  localparam int CODE_W  = 4;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [CODE_W-1:0]  code_t;

  // Code returned for anything outside the map, treated as solid terrain.
  localparam code_t SOLID_CODE = 4'hF;

  // Multiply a row index by a constant stride using only shifts and adds.
  // The full 18-bit result is kept: 511 * 500 + 511 still fits.
  function automatic addr_t mul_const(input coord_t y, input int unsigned k);
    addr_t acc;
    acc = '0;
    for (int b = 0; b < ADDR_W; b++) begin
      if (k[b]) begin
        acc = acc + (addr_t'(y) << b);
      end
    end
    return acc;
  endfunction

endpackage

// File: rtl/collision_query_arbiter_if.sv
// Requester, ROM and response signals of the collision query arbiter.
interface collision_query_arbiter_if
  import collision_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF
);

  logic   [NUM_REQ-1:0] req_valid;
  coord_t [NUM_REQ-1:0] req_x;
  coord_t [NUM_REQ-1:0] req_y;
  logic   [NUM_REQ-1:0] req_ready;
  addr_t                collision_address;
  code_t                q_collision;
  logic   [NUM_REQ-1:0] rsp_valid;
  code_t                rsp_data;
  logic                 busy;

  // Arbiter side.
  modport slave (
    input  req_valid, req_x, req_y, q_collision,
    output req_ready, collision_address, rsp_valid, rsp_data, busy
  );

  // Requesters plus collision ROM side.
  modport master (
    output req_valid, req_x, req_y, q_collision,
    input  req_ready, collision_address, rsp_valid, rsp_data, busy
  );

endinterface

// File: rtl/collision_query_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: searches from ptr upward, wrapping.
module rr_arbiter
  import collision_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  localparam logic [PTR_W:0] N_EXT = (PTR_W+1)'(NUM_REQ);

  logic           found;
  logic [PTR_W:0] pos;

  // Grant the first requester at or after ptr; the extra bit in pos absorbs the wrap.
  always_comb begin
    grant = '0;
    found = 1'b0;
    pos   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos = {1'b0, ptr} + (PTR_W+1)'(i);
      if (pos >= N_EXT) begin
        pos = pos - N_EXT;
      end
      if (!found && req[pos[PTR_W-1:0]]) begin
        grant[pos[PTR_W-1:0]] = 1'b1;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/collision_query_arbiter.sv
// Shares one collision ROM read port between several requesters.
// Accept in cycle N, address out in N+1, response strobe in N+2.
module collision_query_arbiter
  import collision_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int MAP_W   = MAP_W_DEF,
  parameter int MAP_H   = MAP_H_DEF
) (
  input logic clock,
  input logic Reset,
  collision_query_arbiter_if.slave bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  // Per-stage tag that travels alongside the ROM access.
  typedef struct packed {
    logic               valid;
    logic [NUM_REQ-1:0] id;
    logic               oob;
  } stage_t;

  logic [PTR_W-1:0]   ptr;
  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   grant_idx;
  logic               accept;
  coord_t             sel_x;
  coord_t             sel_y;
  logic               sel_oob;
  addr_t              sel_addr;
  stage_t             s1;
  stage_t             s2;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .req   (bus.req_valid),
    .ptr   (ptr),
    .grant (grant)
  );

  // A grant is only ever raised for a valid requester, so it doubles as the acceptance.
  assign bus.req_ready = grant;
  assign accept        = |grant;

  // Steer the granted requester's coordinates onto the single shared address path.
  always_comb begin
    sel_x     = '0;
    sel_y     = '0;
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_x     = bus.req_x[i];
        sel_y     = bus.req_y[i];
        grant_idx = PTR_W'(i);
      end
    end
  end

  // Bounds test and row-major address of the selected query.
  always_comb begin
    sel_oob  = (32'(sel_x) >= MAP_W) || (32'(sel_y) >= MAP_H);
    sel_addr = mul_const(sel_y, MAP_W) + addr_t'(sel_x);
  end

  // Move the round-robin pointer just past each accepted requester.
  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + PTR_W'(1);
    end
  end

  // Stage 1 tags the query and drives the ROM address; stage 2 lines the tag up with ROM data.
  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      s1                    <= '0;
      s2                    <= '0;
      bus.collision_address <= '0;
    end else begin
      s1.valid <= accept;
      s1.id    <= grant;
      s1.oob   <= sel_oob;
      if (accept && !sel_oob) begin
        bus.collision_address <= sel_addr;
      end
      s2 <= s1;
    end
  end

  assign bus.rsp_valid = s2.valid ? s2.id : '0;
  assign bus.rsp_data  = !s2.valid ? '0 : (s2.oob ? SOLID_CODE : bus.q_collision);
  assign bus.busy      = s1.valid | s2.valid;

endmodule

// File: tb/tb_collision_query_arbiter.sv
// Randomised scoreboard bench for collision_query_arbiter with a 1-cycle ROM model.
module tb_collision_query_arbiter;
  import collision_pkg::*;

  localparam int NR = 4;
  localparam int MW = 500;
  localparam int MH = 500;

  typedef struct {
    int id;
    int data;
    int due;
  } exp_t;

  logic clock = 1'b0;
  logic Reset;
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  int   model_ptr  = 0;
  int   model_addr = 0;
  logic [NR-1:0] acc_mask = '0;
  exp_t sb[$];

  logic   [NR-1:0] vld;
  coord_t [NR-1:0] xs;
  coord_t [NR-1:0] ys;

  collision_query_arbiter_if #(.NUM_REQ(NR)) bus ();

  collision_query_arbiter #(
    .NUM_REQ (NR),
    .MAP_W   (MW),
    .MAP_H   (MH)
  ) dut (
    .clock (clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Collision ROM: registered read, contents are the low nibble of the address.
  always @(posedge clock) bus.q_collision <= bus.collision_address[3:0];

  task automatic check_output(input string name, input longint actual, input longint expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference model: round-robin rule, address rule and expected responses.
  task automatic model_step();
    int g;
    int x;
    int y;
    int code;
    bit oob;
    logic [NR-1:0] exp_ready;
    if (Reset) begin
      sb.delete();
      model_ptr  = 0;
      model_addr = 0;
      acc_mask   = '0;
      check_output("reset_address", bus.collision_address, 0);
      check_output("reset_rsp_valid", bus.rsp_valid, 0);
      check_output("reset_rsp_data", bus.rsp_data, 0);
      check_output("reset_busy", bus.busy, 0);
      return;
    end
    g = -1;
    for (int k = 0; k < NR; k++) begin
      if (g < 0 && bus.req_valid[(model_ptr + k) % NR]) g = (model_ptr + k) % NR;
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    check_output("grant", bus.req_ready, exp_ready);
    check_output("collision_address", bus.collision_address, model_addr);
    acc_mask = exp_ready;
    if (g >= 0) begin
      x    = bus.req_x[g];
      y    = bus.req_y[g];
      oob  = (x >= MW) || (y >= MH);
      code = oob ? 15 : ((y * MW + x) % 16);
      if (!oob) model_addr = y * MW + x;
      sb.push_back('{g, code, cyc + 2});
      model_ptr = (g + 1) % NR;
    end
  endtask

  // Monitor: pops the scoreboard when a response is due and checks busy.
  task automatic monitor_step();
    exp_t e;
    logic [NR-1:0] exp_v;
    bit exp_busy;
    if (Reset) return;
    exp_busy = 1'b0;
    foreach (sb[j]) begin
      if (sb[j].due == cyc || sb[j].due == cyc + 1) exp_busy = 1'b1;
    end
    check_output("busy", bus.busy, exp_busy);
    exp_v = '0;
    if (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      exp_v[e.id] = 1'b1;
      check_output("rsp_valid", bus.rsp_valid, exp_v);
      check_output("rsp_data", bus.rsp_data, e.data);
    end else begin
      check_output("rsp_valid_idle", bus.rsp_valid, exp_v);
    end
  endtask

  always @(negedge clock) model_step();
  always @(negedge clock) monitor_step();

  task automatic drive();
    bus.req_valid = vld;
    bus.req_x     = xs;
    bus.req_y     = ys;
  endtask

  // Advance one cycle; requests accepted last cycle are withdrawn.
  task automatic tick();
    @(posedge clock);
    #1;
    vld = vld & ~acc_mask;
    drive();
  endtask

  task automatic set_req(input int i, input int x, input int y);
    vld[i] = 1'b1;
    xs[i]  = coord_t'(x);
    ys[i]  = coord_t'(y);
    drive();
  endtask

  function automatic int pick_coord();
    int r;
    r = $urandom_range(0, 11);
    case (r)
      0:       return 0;
      1:       return 499;
      2:       return 500;
      3:       return 511;
      default: return $urandom_range(0, 499);
    endcase
  endfunction

  task automatic apply_reset(input int n);
    Reset = 1'b1;
    repeat (n) tick();
    Reset = 1'b0;
  endtask

  task automatic apply_stimulus(input int n);
    for (int c = 0; c < n; c++) begin
      tick();
      if ($urandom_range(0, 199) == 0) apply_reset(2);
      for (int i = 0; i < NR; i++) begin
        if (vld[i]) begin
          if ($urandom_range(0, 19) == 0) vld[i] = 1'b0;
        end else if ($urandom_range(0, 9) < 6) begin
          vld[i] = 1'b1;
          xs[i]  = coord_t'(pick_coord());
          ys[i]  = coord_t'(pick_coord());
        end
      end
      drive();
    end
  endtask

  initial begin
    Reset = 1'b1;
    vld   = '0;
    xs    = '0;
    ys    = '0;
    $display("[TB] start");

    // All requesters held valid from reset: grants rotate 0,1,2,3,0,...
    for (int i = 0; i < NR; i++) begin
      vld[i] = 1'b1;
      xs[i]  = coord_t'(i * 7 + 1);
      ys[i]  = coord_t'(i);
    end
    drive();
    repeat (3) tick();
    Reset = 1'b0;
    repeat (6) begin
      tick();
      for (int i = 0; i < NR; i++) begin
        if (!vld[i]) set_req(i, $urandom_range(0, 499), $urandom_range(0, 499));
      end
    end
    vld = '0;
    drive();
    repeat (4) tick();

    // Single query, out-of-bounds and corner cases.
    set_req(0, 3, 2);
    repeat (4) tick();
    set_req(1, 500, 0);
    repeat (4) tick();
    set_req(3, 0, 500);
    repeat (4) tick();
    set_req(2, 499, 499);
    repeat (4) tick();
    set_req(0, 511, 511);
    repeat (4) tick();

    // Reset one cycle after a grant; afterwards the pointer must restart at 0.
    set_req(1, 10, 10);
    tick();
    Reset = 1'b1;
    tick();
    set_req(0, 20, 20);
    set_req(3, 30, 30);
    tick();
    Reset = 1'b0;
    repeat (5) tick();

    // Requester 2 alone, re-requesting every cycle.
    set_req(2, 5, 6);
    repeat (8) begin
      tick();
      set_req(2, $urandom_range(0, 499), $urandom_range(0, 499));
    end
    tick();
    vld = '0;
    drive();
    repeat (4) tick();

    apply_stimulus(600);

    vld = '0;
    drive();
    repeat (6) tick();
    check_output("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
